// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I OP-IMM/OP/BRANCH decode stage with operand forwarding
// and a one-entry valid/ready output register.
module id_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   inst_addr_i,
  input  logic [31:0]       inst_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              ex_wen_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic [XLEN-1:0]   ex_rd_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wen_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  inst_cnt_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  logic              uses_rs1;
  logic              uses_rs2;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;

  // Forwarded EX result wins over the register file; x0 always reads as zero.
  function automatic logic [XLEN-1:0] src_value(
    input logic [REG_AW-1:0] addr,
    input logic [XLEN-1:0]   rf_data,
    input logic              fwd_wen,
    input logic [REG_AW-1:0] fwd_addr,
    input logic [XLEN-1:0]   fwd_data
  );
    logic [XLEN-1:0] v;
    if (addr == '0) begin
      v = '0;
    end else if ((FWD_EN != 0) && fwd_wen && (fwd_addr == addr)) begin
      v = fwd_data;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  always_comb begin
    uses_rs1 = (opcode == OPC_OP_IMM) || (opcode == OPC_OP) || (opcode == OPC_BRANCH);
    uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_BRANCH);
    rs1_addr = uses_rs1 ? REG_AW'(inst_i[19:15]) : '0;
    rs2_addr = uses_rs2 ? REG_AW'(inst_i[24:20]) : '0;
    rs1_val  = src_value(rs1_addr, rs1_data_i, ex_wen_i, ex_rd_addr_i, ex_rd_data_i);
    rs2_val  = src_value(rs2_addr, rs2_data_i, ex_wen_i, ex_rd_addr_i, ex_rd_data_i);
  end

  assign rs1_addr_o = rs1_addr;
  assign rs2_addr_o = rs2_addr;

  logic              dec_legal;
  logic              dec_writes;
  logic [XLEN-1:0]   dec_op1;
  logic [XLEN-1:0]   dec_op2;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_wen;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   shamt;

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign shamt = {{(XLEN-5){1'b0}}, inst_i[24:20]};

  always_comb begin
    dec_legal  = 1'b0;
    dec_writes = 1'b0;
    dec_op1    = '0;
    dec_op2    = '0;
    dec_rd     = '0;
    dec_wen    = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec_writes = 1'b1;
        dec_op1    = rs1_val;
        case (funct3)
          3'b001: begin
            dec_legal = (funct7 == F7_BASE);
            dec_op2   = shamt;
          end
          3'b101: begin
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            dec_op2   = shamt;
          end
          default: begin
            dec_legal = 1'b1;
            dec_op2   = imm_i;
          end
        endcase
      end
      OPC_OP: begin
        dec_writes = 1'b1;
        dec_op1    = rs1_val;
        dec_op2    = rs2_val;
        dec_legal  = (funct7 == F7_BASE) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_BRANCH: begin
        dec_op1   = rs1_val;
        dec_op2   = rs2_val;
        dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
    // Illegal encodings collapse to a NOP bundle.
    if (!dec_legal) begin
      dec_op1 = '0;
      dec_op2 = '0;
    end else if (dec_writes) begin
      dec_rd  = REG_AW'(inst_i[11:7]);
      dec_wen = (dec_rd != '0);
    end
  end

  logic              valid_q,     valid_d;
  logic [XLEN-1:0]   inst_addr_q, inst_addr_d;
  logic [31:0]       inst_q,      inst_d;
  logic [XLEN-1:0]   op1_q,       op1_d;
  logic [XLEN-1:0]   op2_q,       op2_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic              wen_q,       wen_d;
  logic              illegal_q,   illegal_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              accept;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    valid_d     = valid_q;
    inst_addr_d = inst_addr_q;
    inst_d      = inst_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      inst_addr_d = inst_addr_i;
      inst_d      = inst_i;
      op1_d       = dec_op1;
      op2_d       = dec_op2;
      rd_d        = dec_rd;
      wen_d       = dec_wen;
      illegal_d   = !dec_legal;
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      inst_addr_q <= '0;
      inst_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      inst_addr_q <= inst_addr_d;
      inst_q      <= inst_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign valid_o     = valid_q;
  assign inst_addr_o = inst_addr_q;
  assign inst_o      = inst_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign rd_addr_o   = rd_q;
  assign reg_wen_o   = wen_q;
  assign illegal_o   = illegal_q;
  assign inst_cnt_o  = cnt_q;

endmodule
